// File: rtl/nh_dff_pipe.sv
// WIDTH-bit core register with load/toggle/set/clear update modes, feeding a
// DEPTH-stage delay line with a runtime-selectable output tap and fill tracking.
module nh_dff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [TAP_W-1:0] tap_sel,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             changed
);

  localparam int                FILL_W   = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  typedef enum logic [1:0] {
    MODE_LOAD   = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_SET    = 2'b10,
    MODE_CLEAR  = 2'b11
  } mode_e;

  logic [WIDTH-1:0]  stage [DEPTH];
  logic [WIDTH-1:0]  core_next;
  logic [FILL_W-1:0] fill;
  logic [TAP_W-1:0]  tap_eff;

  always_comb begin
    // NOTE: default assigned first so every path drives core_next; no latch is inferred.
    core_next = stage[0];
    unique case (mode_e'(mode))
      MODE_LOAD:   core_next = d;
      MODE_TOGGLE: core_next = stage[0] ^ d;
      MODE_SET:    core_next = stage[0] | d;
      MODE_CLEAR:  core_next = stage[0] & ~d;
    endcase
  end

  // NOTE: every stage is reset, not just the core, so q is defined the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      fill    <= '0;
      changed <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      fill    <= '0;
      changed <= 1'b0;
    end else if (en) begin
      // NOTE: non-blocking, so each stage takes its neighbour's pre-edge value.
      stage[0] <= core_next;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      if (fill != FILL_MAX) fill <= fill + FILL_W'(1);
      changed <= (core_next != stage[0]);
    end else begin
      changed <= 1'b0;
    end
  end

  // Out-of-range taps clamp to the last stage rather than wrapping.
  always_comb begin
    tap_eff = '0;
    if (DEPTH > 1) begin
      if (int'(tap_sel) < DEPTH) tap_eff = tap_sel;
      else                       tap_eff = TAP_W'(DEPTH - 1);
    end
  end

  always_comb begin
    q = stage[0];
    for (int i = 1; i < DEPTH; i++) begin
      if (tap_eff == TAP_W'(i)) q = stage[i];
    end
  end

  assign valid = int'(fill) > int'(tap_eff);

endmodule

// File: tb/tb_nh_dff_pipe.sv
// Bench for nh_dff_pipe: DEPTH=4, 3 and 1 instances share stimulus and are
// compared against a history-queue model of the written core values.
module tb_nh_dff_pipe;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [1:0] mode;
  logic [7:0] d;
  logic [1:0] tap4, tap3;
  logic [0:0] tap1;
  logic [7:0] q4, q3, q1;
  logic       valid4, valid3, valid1;
  logic       changed4, changed3, changed1;

  nh_dff_pipe #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .d(d),
    .tap_sel(tap4), .q(q4), .valid(valid4), .changed(changed4));

  nh_dff_pipe #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .d(d),
    .tap_sel(tap3), .q(q3), .valid(valid3), .changed(changed3));

  nh_dff_pipe #(.WIDTH(8), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .d(d),
    .tap_sel(tap1), .q(q1), .valid(valid1), .changed(changed1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Core values written since reset/clear, newest first, capped at 4 entries.
  logic [7:0] hist [$];
  int         n_en;
  logic       exp_changed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_stage(input int k);
    return (k < hist.size()) ? hist[k] : 8'h00;
  endfunction

  function automatic int clamp(input int t, input int depth);
    return (t < depth) ? t : depth - 1;
  endfunction

  // Walks every tap value across all three instances, then checks changed.
  task automatic sweep();
    for (int t = 0; t < 4; t++) begin
      tap4 = 2'(t);
      tap3 = 2'(t);
      tap1 = 1'(t);
      #1;
      check($sformatf("d4_q_t%0d", t), q4, exp_stage(clamp(t, 4)));
      check($sformatf("d4_v_t%0d", t), valid4, n_en > clamp(t, 4));
      check($sformatf("d3_q_t%0d", t), q3, exp_stage(clamp(t, 3)));
      check($sformatf("d3_v_t%0d", t), valid3, n_en > clamp(t, 3));
      check($sformatf("d1_q_t%0d", t), q1, exp_stage(0));
      check($sformatf("d1_v_t%0d", t), valid1, n_en > 0);
    end
    check("d4_chg", changed4, exp_changed);
    check("d3_chg", changed3, exp_changed);
    check("d1_chg", changed1, exp_changed);
  endtask

  task automatic model_clear();
    hist.delete();
    n_en        = 0;
    exp_changed = 1'b0;
  endtask

  // Drives one cycle's inputs, updates the model at the edge, then checks.
  task automatic step(input logic e, input logic c, input logic [1:0] m, input logic [7:0] dv);
    logic [7:0] cur, nxt;
    en = e; clr = c; mode = m; d = dv;
    @(posedge clk);
    cur = exp_stage(0);
    if (c) begin
      model_clear();
    end else if (e) begin
      case (m)
        2'b00:   nxt = dv;
        2'b01:   nxt = cur ^ dv;
        2'b10:   nxt = cur | dv;
        default: nxt = cur & ~dv;
      endcase
      hist.push_front(nxt);
      if (hist.size() > 4) void'(hist.pop_back());
      n_en++;
      exp_changed = (nxt != cur);
    end else begin
      exp_changed = 1'b0;
    end
    sweep();
    @(negedge clk);
  endtask

  task automatic expect4(input string tag, input logic [1:0] t, input logic [7:0] qv, input logic vv);
    tap4 = t;
    #1;
    check({tag, "_q"}, q4, qv);
    check({tag, "_v"}, valid4, vv);
  endtask

  // Asserts reset between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_q4", q4, 8'h00);
    check("rst_v4", valid4, 1'b0);
    check("rst_c4", changed4, 1'b0);
    model_clear();
    @(negedge clk);
    sweep();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; mode = 2'b00; d = 8'h00;
    tap4 = '0; tap3 = '0; tap1 = '0;
    model_clear();
    #1;
    check("init_q4", q4, 8'h00);
    check("init_v4", valid4, 1'b0);
    check("init_c4", changed4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-stream after three loads of 0xA5.
    repeat (3) step(1'b1, 1'b0, 2'b00, 8'hA5);
    check("a5_loaded", q4, exp_stage(clamp(int'(tap4), 4)));
    async_reset();

    // Delay line: the first value reaches tap 3 on the fourth enabled edge.
    step(1'b1, 1'b0, 2'b00, 8'h01);
    expect4("dl_e1", 2'd3, 8'h00, 1'b0);
    step(1'b1, 1'b0, 2'b00, 8'h02);
    step(1'b1, 1'b0, 2'b00, 8'h03);
    expect4("dl_e3", 2'd3, 8'h00, 1'b0);
    step(1'b1, 1'b0, 2'b00, 8'h04);
    expect4("dl_e4_t3", 2'd3, 8'h01, 1'b1);
    expect4("dl_e4_t0", 2'd0, 8'h04, 1'b1);

    // Core update modes.
    step(1'b1, 1'b0, 2'b00, 8'hF0);
    step(1'b1, 1'b0, 2'b01, 8'hFF);
    expect4("tog", 2'd0, 8'h0F, 1'b1);
    check("tog_chg", changed4, 1'b1);
    step(1'b1, 1'b0, 2'b10, 8'h30);
    expect4("set", 2'd0, 8'h3F, 1'b1);
    step(1'b1, 1'b0, 2'b11, 8'h0F);
    expect4("clrb", 2'd0, 8'h30, 1'b1);
    step(1'b1, 1'b0, 2'b10, 8'h10);
    expect4("set_nop", 2'd0, 8'h30, 1'b1);
    check("set_nop_chg", changed4, 1'b0);

    // Stall with varying operands, then resume.
    step(1'b1, 1'b0, 2'b00, 8'h11);
    step(1'b1, 1'b0, 2'b00, 8'h22);
    step(1'b1, 1'b0, 2'b00, 8'h33);
    step(1'b1, 1'b0, 2'b00, 8'h44);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'($urandom_range(0, 3)), 8'($urandom));
    expect4("stall_t3", 2'd3, 8'h11, 1'b1);
    check("stall_chg", changed4, 1'b0);
    step(1'b1, 1'b0, 2'b00, 8'h55);
    expect4("resume_t1", 2'd1, 8'h44, 1'b1);

    // Clear beats enable.
    step(1'b1, 1'b1, 2'b00, 8'hEE);
    expect4("clr_t0", 2'd0, 8'h00, 1'b0);
    expect4("clr_t3", 2'd3, 8'h00, 1'b0);
    check("clr_chg", changed4, 1'b0);
    step(1'b1, 1'b0, 2'b00, 8'h77);
    expect4("post_clr_t0", 2'd0, 8'h77, 1'b1);
    expect4("post_clr_t1", 2'd1, 8'h00, 1'b0);

    // Randomised traffic with occasional clears and asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) async_reset();
      else step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                2'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
